// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back source codes, sequencer state type and source classifiers
package wb_pkg;

    localparam logic [3:0] SRC_ALUOUT   = 4'd0;
    localparam logic [3:0] SRC_LOADSIZE = 4'd1;
    localparam logic [3:0] SRC_MEMDATA  = 4'd2;
    localparam logic [3:0] SRC_RD       = 4'd3;
    localparam logic [3:0] SRC_SE1_32   = 4'd4;
    localparam logic [3:0] SRC_CONST227 = 4'd5;
    localparam logic [3:0] SRC_REGB     = 4'd6;
    localparam logic [3:0] SRC_HI       = 4'd7;
    localparam logic [3:0] SRC_LO       = 4'd8;
    localparam logic [3:0] SRC_MAX      = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2,
        ST_WRITE    = 2'd3
    } wb_state_t;

    function automatic logic is_mem_src(input logic [3:0] src);
        return (src == SRC_LOADSIZE) || (src == SRC_MEMDATA);
    endfunction

    function automatic logic is_md_src(input logic [3:0] src);
        return (src == SRC_HI) || (src == SRC_LO);
    endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// rtl/wb_wait_counter.sv - loadable down-counter with zero flag, stops at zero
module wb_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - write-back sequencer; WB_MD_TIMEOUT_EN adds a mult/div wait timeout
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [3:0] req_src,
    input  logic [4:0] req_rd,
    output logic       req_ready,
    input  logic       muldiv_done,
    input  logic       flush,
    output logic [3:0] memtoreg_sel,
    output logic       reg_write,
    output logic [4:0] wb_rd,
    output logic       wb_done,
    output logic       err
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("wb_sequencer: MEM_LAT out of range");
    end
    if (MD_TIMEOUT < 1 || MD_TIMEOUT > 255) begin : g_bad_md_timeout
        $error("wb_sequencer: MD_TIMEOUT out of range");
    end

    localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

    wb_state_t  state, state_next;
    logic [3:0] src_q;
    logic [4:0] rd_q;
    logic       err_q;
    logic       capture;
    logic       set_err;
    logic       mem_load, mem_dec, mem_zero;

    wb_wait_counter #(.W(4)) u_mem_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (mem_load),
        .load_val (MEM_LOAD),
        .dec      (mem_dec),
        .zero     (mem_zero)
    );

`ifdef WB_MD_TIMEOUT_EN
    localparam logic [7:0] MD_LOAD = 8'(MD_TIMEOUT - 1);
    logic md_load, md_dec, md_zero;

    wb_wait_counter #(.W(8)) u_md_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (md_load),
        .load_val (MD_LOAD),
        .dec      (md_dec),
        .zero     (md_zero)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            src_q <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= set_err;
            if (capture) begin
                src_q <= req_src;
                rd_q  <= req_rd;
            end
        end
    end

    // flush outranks every other exit from the wait states
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        set_err    = 1'b0;
        mem_load   = 1'b0;
        mem_dec    = 1'b0;
`ifdef WB_MD_TIMEOUT_EN
        md_load    = 1'b0;
        md_dec     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    if (req_src > SRC_MAX) begin
                        set_err = 1'b1;
                    end else begin
                        capture = 1'b1;
                        if (is_mem_src(req_src)) begin
                            state_next = ST_MEM_WAIT;
                            mem_load   = 1'b1;
                        end else if (is_md_src(req_src)) begin
                            state_next = ST_MD_WAIT;
`ifdef WB_MD_TIMEOUT_EN
                            md_load    = 1'b1;
`endif
                        end else begin
                            state_next = ST_WRITE;
                        end
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (mem_zero) begin
                    state_next = ST_WRITE;
                end else begin
                    mem_dec = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (muldiv_done) begin
                    state_next = ST_WRITE;
`ifdef WB_MD_TIMEOUT_EN
                end else if (md_zero) begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end else begin
                    md_dec = 1'b1;
`endif
                end
            end
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req_ready    = (state == ST_IDLE) && !flush;
    assign memtoreg_sel = (state == ST_IDLE) ? 4'd0 : src_q;
    assign wb_rd        = (state == ST_IDLE) ? 5'd0 : rd_q;
    assign wb_done      = (state == ST_WRITE);
    assign reg_write    = (state == ST_WRITE) && (rd_q != 5'd0);
    assign err          = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - directed bench for wb_sequencer; WB_MD_TIMEOUT_EN selects the timeout case
module tb_wb_sequencer;

`ifdef WB_MD_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 40;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [3:0] req_src;
    logic [4:0] req_rd;
    logic       req_ready;
    logic       muldiv_done;
    logic       flush;
    logic [3:0] memtoreg_sel;
    logic       reg_write;
    logic [4:0] wb_rd;
    logic       wb_done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    wb_sequencer #(.MEM_LAT(2), .MD_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_src      (req_src),
        .req_rd       (req_rd),
        .req_ready    (req_ready),
        .muldiv_done  (muldiv_done),
        .flush        (flush),
        .memtoreg_sel (memtoreg_sel),
        .reg_write    (reg_write),
        .wb_rd        (wb_rd),
        .wb_done      (wb_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] src, input logic [4:0] rd);
        req_valid = 1'b1;
        req_src   = src;
        req_rd    = rd;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_src = '0; req_rd = '0;
        muldiv_done = 1'b0; flush = 1'b0;
        #2;
        check("rst_sel", memtoreg_sel, 0);
        check("rst_rd", wb_rd, 0);
        check("rst_wr", reg_write, 0);
        check("rst_done", wb_done, 0);
        check("rst_err", err, 0);
        cyc(); cyc();
        reset_n = 1'b1;
        half();
        check("rst_ready", req_ready, 1);

        // immediate source, then a request held through WRITE
        cyc(); req(4'd0, 5'd5);
        half(); check("t1_ready", req_ready, 1); check("t1_nowr", reg_write, 0);
        cyc(); req(4'd3, 5'd7);
        half();
        check("t1_wr", reg_write, 1); check("t1_sel", memtoreg_sel, 0);
        check("t1_rd", wb_rd, 5); check("t1_done", wb_done, 1);
        check("t1_noaccept_in_write", req_ready, 0);
        cyc(); half(); check("t1_b2b_ready", req_ready, 1); check("t1_b2b_nowr", reg_write, 0);
        cyc(); req_valid = 1'b0;
        half(); check("t1_b2b_wr", reg_write, 1); check("t1_b2b_rd", wb_rd, 7); check("t1_b2b_sel", memtoreg_sel, 3);
        cyc(); half();
        check("t1_idle_sel", memtoreg_sel, 0); check("t1_idle_rd", wb_rd, 0); check("t1_idle_done", wb_done, 0);

        // muldiv_done in IDLE has no effect
        muldiv_done = 1'b1; half(); cyc(); muldiv_done = 1'b0;
        half(); check("md_idle_nowr", reg_write, 0); check("md_idle_ready", req_ready, 1);

        // load source, MEM_LAT=2
        cyc(); req(4'd2, 5'd9);
        half(); check("t2_ready", req_ready, 1);
        cyc(); req_valid = 1'b0;
        half(); check("t2_sel1", memtoreg_sel, 2); check("t2_rd1", wb_rd, 9); check("t2_nowr1", reg_write, 0);
        cyc(); half(); check("t2_nowr2", reg_write, 0);
        cyc(); half(); check("t2_wr", reg_write, 1); check("t2_done", wb_done, 1);
        cyc(); half(); check("t2_ready_after", req_ready, 1);

        // HI source with muldiv_done at T+10
        cyc(); req(4'd7, 5'd3);
        half();
        cyc(); req_valid = 1'b0;
        repeat (9) cyc();
        muldiv_done = 1'b1;
        half(); check("t3_nowr", reg_write, 0); check("t3_sel", memtoreg_sel, 7); check("t3_busy", req_ready, 0);
        cyc(); muldiv_done = 1'b0;
        half(); check("t3_wr", reg_write, 1); check("t3_rd", wb_rd, 3);
        cyc(); half(); check("t3_ready_after", req_ready, 1);

        // flush during MD_WAIT at T+5
        cyc(); req(4'd8, 5'd4);
        half();
        cyc(); req_valid = 1'b0;
        repeat (4) cyc();
        flush = 1'b1;
        half(); check("t3f_busy", req_ready, 0);
        cyc(); flush = 1'b0;
        half(); check("t3f_ready", req_ready, 1); check("t3f_nodone", wb_done, 0); check("t3f_nowr", reg_write, 0);

        // flush in IDLE blocks acceptance
        cyc(); req(4'd0, 5'd1); flush = 1'b1;
        half(); check("fi_ready", req_ready, 0);
        cyc(); req_valid = 1'b0; flush = 1'b0;
        half(); check("fi_nowr", reg_write, 0); check("fi_nodone", wb_done, 0);

        // flush in WRITE does not cancel
        cyc(); req(4'd6, 5'd6);
        half();
        cyc(); req_valid = 1'b0; flush = 1'b1;
        half(); check("fw_wr", reg_write, 1); check("fw_rd", wb_rd, 6);
        cyc(); flush = 1'b0;
        half(); check("fw_ready", req_ready, 1);

        // illegal code
        cyc(); req(4'd12, 5'd8);
        half(); check("t4_ready", req_ready, 1);
        cyc(); req_valid = 1'b0;
        half(); check("t4_err", err, 1); check("t4_nowr", reg_write, 0); check("t4_idle", req_ready, 1);
        cyc(); half(); check("t4_err_pulse", err, 0);

        // rd==0 write
        cyc(); req(4'd5, 5'd0);
        half();
        cyc(); req_valid = 1'b0;
        half(); check("t4z_nowr", reg_write, 0); check("t4z_done", wb_done, 1); check("t4z_sel", memtoreg_sel, 5);

`ifdef WB_MD_TIMEOUT_EN
        // timeout after TO cycles of MD_WAIT
        cyc(); req(4'd8, 5'd2);
        half();
        cyc(); req_valid = 1'b0;
        repeat (3) cyc();
        half(); check("t5_noerr", err, 0); check("t5_busy", req_ready, 0); check("t5_sel", memtoreg_sel, 8);
        cyc(); half(); check("t5_err", err, 1); check("t5_ready", req_ready, 1); check("t5_nowr", reg_write, 0);
        cyc(); half(); check("t5_err_pulse", err, 0);
`else
        // MD_WAIT has no timeout: still waiting after 50 cycles
        cyc(); req(4'd8, 5'd2);
        half();
        cyc(); req_valid = 1'b0;
        repeat (49) cyc();
        half(); check("t5_busy", req_ready, 0); check("t5_noerr", err, 0);
        muldiv_done = 1'b1;
        cyc(); muldiv_done = 1'b0;
        half(); check("t5_wr", reg_write, 1); check("t5_rd", wb_rd, 2); check("t5_sel", memtoreg_sel, 8);
        cyc();
`endif

        // reset during MEM_WAIT
        cyc(); req(4'd1, 5'd11);
        half();
        cyc(); req_valid = 1'b0;
        half(); check("t6_sel_pre", memtoreg_sel, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_sel", memtoreg_sel, 0); check("t6_rd", wb_rd, 0);
        check("t6_wr", reg_write, 0); check("t6_ready", req_ready, 1);
        cyc(); reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            half(); check("t6_nowr_after", reg_write, 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
